// File: rtl/ntt_lane_collector.sv
// ntt_lane_collector: ping-pong frame collector for the twiddle-stage lane stream.
// Optional feature macro: COLLECTOR_FRAME_CNT_EN (adds the frame_cnt output).
`default_nettype none

module ntt_lane_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 1024,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   lane_in,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [LANES*DATA_WIDTH-1:0]   rd_data,
    output logic                          rd_valid,
    output logic                          frame_ready,
    input  logic                          frame_release,
    output logic                          overflow,
`ifdef COLLECTOR_FRAME_CNT_EN
    output logic [15:0]                   frame_cnt,
`endif
    input  logic                          clr_overflow
);

    localparam int LW = LANES * DATA_WIDTH;

    logic [LW-1:0]         bank_q [0:2*SIZE-1];

    logic [ADDR_WIDTH-1:0] wr_idx_q,   wr_idx_d;
    logic                  wr_bank_q,  wr_bank_d;
    logic                  rd_bank_q,  rd_bank_d;
    logic [1:0]            full_cnt_q, full_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [LW-1:0]         rd_data_q;
    logic                  rd_valid_q;

    logic w_wr, w_done, w_rel, w_rd, w_full;

    always_comb begin
        w_full = (full_cnt_q == 2'd2);
        w_wr   = valid_in && !w_full;
        w_done = w_wr && (wr_idx_q == ADDR_WIDTH'(SIZE - 1));
        w_rel  = frame_release && (full_cnt_q != 2'd0);
        w_rd   = rd_en && (full_cnt_q != 2'd0);

        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_cnt_d = full_cnt_q;
        overflow_d = overflow_q;

        // SIZE is a power of two, so the index wraps to 0 on its own
        if (w_wr) begin
            wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
        end
        if (w_done) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (w_rel) begin
            rd_bank_d = ~rd_bank_q;
        end
        case ({w_done, w_rel})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase

        // A drop in the same cycle takes priority over the clear
        if (valid_in && w_full) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            bank_q[{wr_bank_q, wr_idx_q}] <= lane_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_cnt_q <= 2'd0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_cnt_q <= full_cnt_d;
            overflow_q <= overflow_d;
            rd_valid_q <= w_rd;
            // Read uses the pre-toggle rd_bank even when released this cycle
            if (w_rd) begin
                rd_data_q <= bank_q[{rd_bank_q, rd_addr}];
            end
        end
    end

`ifdef COLLECTOR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (w_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign frame_ready = (full_cnt_q != 2'd0);
    assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_lane_collector.sv
// Randomized and directed bench for ntt_lane_collector against a frame-queue reference model.
`default_nettype none

module tb_ntt_lane_collector;

    localparam int DW = 32;
    localparam int SZ = 4;
    localparam int LN = 8;
    localparam int LW = DW * LN;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [LW-1:0] lane_in = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [LW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic          frame_release = 1'b0;
    logic          overflow;
    logic          clr_overflow = 1'b0;
`ifdef COLLECTOR_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    ntt_lane_collector #(
        .DATA_WIDTH(DW), .SIZE(SZ), .LANES(LN), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .lane_in(lane_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_release(frame_release),
        .overflow(overflow),
`ifdef COLLECTOR_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: completed frames are a FIFO of at most two; a partial frame accumulates.
    logic [SZ*LW-1:0] frames[$];
    logic [SZ*LW-1:0] part;
    int               pcnt;
    logic             m_ovf;
    logic [LW-1:0]    m_rd_data;
    logic             m_rd_valid;
    int               m_fcnt;

    function automatic logic [LW-1:0] mk(input int k);
        logic [LW-1:0] v;
        for (int j = 0; j < LN; j++) v[j*DW +: DW] = DW'(16 * k + j);
        return v;
    endfunction

    function automatic logic [LW-1:0] rnd_vec();
        logic [LW-1:0] v;
        for (int j = 0; j < LN; j++) v[j*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        frames.delete();
        part = '0;
        pcnt = 0;
        m_ovf = 1'b0;
        m_rd_data = '0;
        m_rd_valid = 1'b0;
        m_fcnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [LW-1:0] d, input logic re,
                              input logic [AW-1:0] a, input logic rel, input logic clr);
        logic [SZ*LW-1:0] fr;
        logic ready, full, push;
        ready = (frames.size() > 0);
        full  = (frames.size() == 2);
        push  = 1'b0;
        if (re && ready) begin
            fr = frames[0];
            m_rd_data = fr[int'(a)*LW +: LW];
            m_rd_valid = 1'b1;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (v && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (v && !full) begin
            part[pcnt*LW +: LW] = d;
            pcnt++;
            if (pcnt == SZ) begin
                push = 1'b1;
                pcnt = 0;
                m_fcnt = (m_fcnt + 1) % 65536;
            end
        end
        if (rel && ready) void'(frames.pop_front());
        if (push) frames.push_back(part);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"}, LW'(frame_ready), LW'(frames.size() > 0));
        chk({tag, ".rvalid"}, LW'(rd_valid), LW'(m_rd_valid));
        chk({tag, ".rdata"}, rd_data, m_rd_data);
        chk({tag, ".ovf"}, LW'(overflow), LW'(m_ovf));
`ifdef COLLECTOR_FRAME_CNT_EN
        chk({tag, ".fcnt"}, LW'(frame_cnt), LW'(m_fcnt));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [LW-1:0] d, input logic re,
                        input logic [AW-1:0] a, input logic rel, input logic clr);
        @(negedge clk);
        valid_in = v; lane_in = d; rd_en = re; rd_addr = a;
        frame_release = rel; clr_overflow = clr;
        model_step(v, d, re, a, rel, clr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        step("idle", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 0; rd_en = 0; frame_release = 0; clr_overflow = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int k;

    initial begin
        model_reset();
        k = 0;
        do_reset();

        // Fill one frame, then read it back
        for (int i = 0; i < SZ; i++) begin
            step("fill", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        chk("fill.ready_after_4th", LW'(frame_ready), LW'(1));
        for (int a = 0; a < SZ; a++) begin
            step("rd", 1'b0, '0, 1'b1, AW'(a), 1'b0, 1'b0);
            chk("fill.lane5", LW'(rd_data[5*DW +: DW]), LW'(16 * a + 5));
        end

        // Second frame without release, then release and read the second frame
        for (int i = 0; i < SZ; i++) begin
            step("pp", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        step("pp.rel", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("pp.rd", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        chk("pp.lane0", LW'(rd_data[0 +: DW]), LW'(64));

        // Refill to two frames, then drop one vector
        for (int i = 0; i < SZ; i++) begin
            step("ov.fill", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        step("ov.drop", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
        k++;
        chk("ov.flag", LW'(overflow), LW'(1));
        step("ov.set_beats_clr", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b1);
        k++;
        step("ov.rel", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("ov.rel2", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < SZ; i++) begin
            step("ov.new", 1'b1, mk(k + i), 1'b0, '0, 1'b0, 1'b0);
        end
        step("ov.rd", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        chk("ov.lane0", LW'(rd_data[0 +: DW]), LW'(16 * k));
        k += SZ;
        step("ov.clr", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("ov.cleared", LW'(overflow), LW'(0));

        // Completion and release in the same cycle with one frame held
        for (int i = 0; i < SZ - 1; i++) begin
            step("bd.part", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        step("bd.both", 1'b1, mk(k), 1'b1, '0, 1'b1, 1'b0);
        k++;
        chk("bd.still_ready", LW'(frame_ready), LW'(1));
        step("bd.rd_new", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        chk("bd.new_lane0", LW'(rd_data[0 +: DW]), LW'(16 * (k - SZ)));
        step("bd.rel", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("bd.rd_empty", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        chk("bd.no_rvalid", LW'(rd_valid), LW'(0));

        // Reset mid-frame
        step("rs.w", 1'b1, mk(k), 1'b0, '0, 1'b0, 1'b0);
        step("rs.w", 1'b1, mk(k + 1), 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        k = 200;
        for (int i = 0; i < SZ; i++) begin
            step("rs.fill", 1'b1, mk(k + i), 1'b0, '0, 1'b0, 1'b0);
        end
        step("rs.rd", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        chk("rs.lane0", LW'(rd_data[0 +: DW]), LW'(16 * k));
        step("rs.rel", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 1'($urandom_range(0, 99) < 70), rnd_vec(),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, SZ - 1)),
                 1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 10));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
